// File: rtl/juggle_pkg.sv
// Shared types for the juggling pipeline front end.
// Holds the throw type, validator states and landing-slot helper.
package juggle_pkg;

  localparam int MAX_PERIOD = 7;

  typedef logic [2:0] throw_t;

  typedef enum logic [1:0] {
    COLLECT,
    CHECK,
    DIVIDE
  } state_e;

  // (idx + t) mod n for idx <= 6, t <= 7, n in 1..7.
  // Unrolled conditional subtracts; n == 0 yields the plain sum.
  function automatic logic [2:0] land_slot(
    input logic [2:0] idx,
    input throw_t     t,
    input logic [2:0] n
  );
    logic [3:0] r;
    r = {1'b0, idx} + {1'b0, t};
    for (int k = 0; k < 13; k++) begin
      if (n != 3'd0 && r >= {1'b0, n}) begin
        r = r - {1'b0, n};
      end
    end
    return r[2:0];
  endfunction

endpackage

// File: rtl/siteswap_validator.sv
// Collects siteswap throws, checks juggleability, derives ball count.
// Accepted patterns are published atomically to the trajectory stage.
module siteswap_validator
  import juggle_pkg::*;
#(
  parameter int MAX_PERIOD = 7,
  parameter int THROW_W    = 3
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [THROW_W-1:0]                digit_in,
  input  logic                              digit_valid_in,
  input  logic                              commit_in,
  input  logic                              clear_in,
  output logic [MAX_PERIOD-1:0][THROW_W-1:0] pattern_out,
  output logic [2:0]                        period_out,
  output logic [2:0]                        num_balls_out,
  output logic                              pattern_valid_out,
  output logic                              error_out,
  output logic                              busy_out
);

  state_e     st_q;
  logic [2:0] len_q;
  logic [2:0] idx_q;
  logic [MAX_PERIOD-1:0] mask_q;
  logic [5:0] sum_q;
  logic [2:0] q_q;
  throw_t     entry_q [MAX_PERIOD];

  logic       app;
  logic       ovf;
  logic [2:0] nlen;
  throw_t     cur;
  logic [2:0] slot;

  // Append/overflow decode and current landing slot.
  always_comb begin
    app  = digit_valid_in && (len_q != 3'(MAX_PERIOD));
    ovf  = digit_valid_in && (len_q == 3'(MAX_PERIOD));
    nlen = len_q + {2'b0, app};
    cur  = entry_q[idx_q];
    slot = land_slot(idx_q, cur, len_q);
  end

  assign busy_out = (st_q != COLLECT);

  // Entry collection, collision scan and ball-count division.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      st_q              <= COLLECT;
      len_q             <= '0;
      idx_q             <= '0;
      mask_q            <= '0;
      sum_q             <= '0;
      q_q               <= '0;
      pattern_out       <= '0;
      period_out        <= '0;
      num_balls_out     <= '0;
      pattern_valid_out <= 1'b0;
      error_out         <= 1'b0;
      for (int i = 0; i < MAX_PERIOD; i++) begin
        entry_q[i] <= '0;
      end
    end else if (clear_in) begin
      st_q      <= COLLECT;
      len_q     <= '0;
      error_out <= 1'b0;
    end else begin
      unique case (st_q)
        COLLECT: begin
          if (ovf) begin
            error_out <= 1'b1;
            len_q     <= '0;
          end else begin
            if (app) begin
              entry_q[len_q] <= digit_in;
              if (len_q == 3'd0) error_out <= 1'b0;
            end
            if (commit_in && nlen == 3'd0) begin
              error_out <= 1'b1;
            end else if (commit_in) begin
              st_q   <= CHECK;
              idx_q  <= '0;
              mask_q <= '0;
              sum_q  <= '0;
            end
            len_q <= nlen;
          end
        end
        CHECK: begin
          if (mask_q[slot]) begin
            error_out <= 1'b1;
            len_q     <= '0;
            st_q      <= COLLECT;
          end else begin
            mask_q[slot] <= 1'b1;
            sum_q        <= sum_q + {3'b0, cur};
            if (idx_q == len_q - 3'd1) begin
              st_q <= DIVIDE;
              q_q  <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        DIVIDE: begin
          if (sum_q >= {3'b0, len_q}) begin
            sum_q <= sum_q - {3'b0, len_q};
            q_q   <= q_q + 3'd1;
          end else begin
            if (q_q == 3'd0) begin
              error_out <= 1'b1;
            end else begin
              for (int i = 0; i < MAX_PERIOD; i++) begin
                pattern_out[i] <= (3'(i) < len_q) ? entry_q[i] : '0;
              end
              period_out        <= len_q;
              num_balls_out     <= q_q;
              pattern_valid_out <= 1'b1;
            end
            len_q <= '0;
            st_q  <= COLLECT;
          end
        end
        default: st_q <= COLLECT;
      endcase
    end
  end

  // Collision-free patterns always divide exactly.
  a_exact_div: assert property (@(posedge clk_in) disable iff (rst_in)
    (st_q == DIVIDE && sum_q < {3'b0, len_q}) |-> sum_q == 6'd0);

endmodule

// File: tb/tb_siteswap_validator.sv
// Randomized scoreboard bench for siteswap_validator.
// Expected results come from an arithmetic siteswap model.
module tb_siteswap_validator;

  logic             clk_in;
  logic             rst_in;
  logic [2:0]       digit_in;
  logic             digit_valid_in;
  logic             commit_in;
  logic             clear_in;
  logic [6:0][2:0]  pattern_out;
  logic [2:0]       period_out;
  logic [2:0]       num_balls_out;
  logic             pattern_valid_out;
  logic             error_out;
  logic             busy_out;

  siteswap_validator dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .digit_in(digit_in),
    .digit_valid_in(digit_valid_in),
    .commit_in(commit_in),
    .clear_in(clear_in),
    .pattern_out(pattern_out),
    .period_out(period_out),
    .num_balls_out(num_balls_out),
    .pattern_valid_out(pattern_valid_out),
    .error_out(error_out),
    .busy_out(busy_out)
  );

  typedef struct packed {
    logic        err;
    logic        valid;
    logic [20:0] pat;
    logic [2:0]  per;
    logic [2:0]  balls;
    logic [4:0]  busy;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [20:0] m_pat = '0;
  logic [2:0]  m_per = '0;
  logic [2:0]  m_balls = '0;
  logic        m_valid = 1'b0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model(input int n, input int t[7], output exp_t e);
    int seen[7];
    int sum;
    int s;
    for (int i = 0; i < 7; i++) seen[i] = 0;
    sum = 0;
    e = '0;
    for (int i = 0; i < n; i++) begin
      s = (i + t[i]) % n;
      if (seen[s] != 0) begin
        e.err = 1'b1;
        e.busy = 5'(i + 1);
        e.valid = m_valid;
        e.pat = m_pat;
        e.per = m_per;
        e.balls = m_balls;
        return;
      end
      seen[s] = 1;
      sum += t[i];
    end
    if (sum / n == 0) begin
      e.err = 1'b1;
      e.busy = 5'(n + 1);
    end else begin
      m_pat = '0;
      for (int i = 0; i < n; i++) m_pat[3*i +: 3] = 3'(t[i]);
      m_per = 3'(n);
      m_balls = 3'(sum / n);
      m_valid = 1'b1;
      e.busy = 5'(n + sum / n + 1);
    end
    e.valid = m_valid;
    e.pat = m_pat;
    e.per = m_per;
    e.balls = m_balls;
  endtask

  task automatic submit(input int n, input int t[7], input bit together);
    exp_t e;
    int k;
    model(n, t, e);
    sb.push_back(e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      digit_valid_in = 1'b1;
      digit_in = 3'(t[i]);
      commit_in = together && (i == n - 1);
    end
    if (!together) begin
      @(negedge clk_in);
      digit_valid_in = 1'b0;
      commit_in = 1'b1;
    end
    @(negedge clk_in);
    digit_valid_in = 1'b0;
    commit_in = 1'b0;
    k = 0;
    while (busy_out && k < 40) begin
      @(negedge clk_in);
      k++;
    end
    if (busy_out) begin
      errors++;
      checks++;
      $display("FAIL busy_timeout: got busy=1 want busy=0");
    end
    @(negedge clk_in);
  endtask

  bit   prev_busy = 1'b0;
  int   bcnt = 0;
  exp_t me;

  always @(posedge clk_in) begin
    #1;
    if (rst_in) begin
      prev_busy = 1'b0;
      bcnt = 0;
    end else if (busy_out) begin
      bcnt++;
      prev_busy = 1'b1;
    end else if (prev_busy) begin
      prev_busy = 1'b0;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_empty: got result want none");
      end else begin
        me = sb.pop_front();
        chk("error", error_out, me.err);
        chk("valid", pattern_valid_out, me.valid);
        chk("pattern", pattern_out, me.pat);
        chk("period", period_out, me.per);
        chk("balls", num_balls_out, me.balls);
        chk("busy_cycles", bcnt, me.busy);
      end
      bcnt = 0;
    end
  end

  int d[7];
  int p[7];
  int n;
  int tmp;
  int j;

  initial begin
    rst_in = 1'b1;
    digit_in = '0;
    digit_valid_in = 1'b0;
    commit_in = 1'b0;
    clear_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_pattern", pattern_out, 0);
    chk("rst_period", period_out, 0);
    chk("rst_balls", num_balls_out, 0);
    chk("rst_valid", pattern_valid_out, 0);
    chk("rst_error", error_out, 0);
    chk("rst_busy", busy_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    d = '{3, 0, 0, 0, 0, 0, 0};
    submit(1, d, 1'b0);
    d = '{4, 4, 1, 0, 0, 0, 0};
    submit(3, d, 1'b0);
    d = '{4, 3, 2, 0, 0, 0, 0};
    submit(3, d, 1'b0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      digit_valid_in = 1'b1;
      digit_in = 3'(i);
      @(negedge clk_in);
      digit_valid_in = 1'b0;
      if (i == 0) chk("first_digit_clears", error_out, 0);
      if (i == 6) chk("seventh_ok", error_out, 0);
      if (i == 7) chk("overflow_err", error_out, 1);
    end
    d = '{5, 3, 1, 0, 0, 0, 0};
    submit(3, d, 1'b0);
    d = '{0, 0, 0, 0, 0, 0, 0};
    submit(2, d, 1'b0);
    d = '{5, 0, 0, 0, 0, 0, 0};
    submit(1, d, 1'b1);

    @(negedge clk_in);
    commit_in = 1'b1;
    @(negedge clk_in);
    commit_in = 1'b0;
    chk("empty_commit_err", error_out, 1);
    chk("empty_commit_busy", busy_out, 0);
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    chk("clear_err", error_out, 0);
    chk("clear_keeps_valid", pattern_valid_out, m_valid);
    chk("clear_keeps_pat", pattern_out, m_pat);

    for (int r = 0; r < 60; r++) begin
      n = $urandom_range(7, 1);
      for (int i = 0; i < 7; i++) d[i] = 0;
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < n; i++) p[i] = i;
        for (int i = n - 1; i > 0; i--) begin
          j = $urandom_range(i, 0);
          tmp = p[i];
          p[i] = p[j];
          p[j] = tmp;
        end
        for (int i = 0; i < n; i++) begin
          d[i] = ((p[i] - i) % n + n) % n;
          while (d[i] + n <= 7 && $urandom_range(1) == 1) d[i] += n;
        end
      end else begin
        for (int i = 0; i < n; i++) d[i] = $urandom_range(7, 0);
      end
      submit(n, d, bit'($urandom_range(1)));
    end

    d = '{7, 7, 7, 0, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      digit_valid_in = 1'b1;
      digit_in = 3'd7;
    end
    @(negedge clk_in);
    digit_valid_in = 1'b0;
    commit_in = 1'b1;
    @(negedge clk_in);
    commit_in = 1'b0;
    chk("check_busy", busy_out, 1);
    rst_in = 1'b1;
    #1;
    chk("midrst_busy", busy_out, 0);
    chk("midrst_valid", pattern_valid_out, 0);
    chk("midrst_pattern", pattern_out, 0);
    chk("midrst_period", period_out, 0);
    chk("midrst_balls", num_balls_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    m_pat = '0;
    m_per = '0;
    m_balls = '0;
    m_valid = 1'b0;
    repeat (20) @(negedge clk_in);
    chk("post_rst_valid", pattern_valid_out, 0);
    submit(3, d, 1'b0);

    repeat (3) @(negedge clk_in);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
